id_stage_reg: RTL and testbench

//  Registered RV32I decode stage: decodes one instruction per handshake, resolves operands
//  (regfile / EX / MEM forwarding / immediate), detects load-use hazards and holds results
//  in an ID/EX pipeline register with valid/ready flow control. Sits between IF/ID and EX.

---
 rtl/id_stage_reg.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_id_stage_reg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_reg.sv
// RV32I decode stage with operand forwarding, load-use stall detection and a
// valid/ready ID/EX pipeline register.
module id_stage_reg #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [31:0]         inst_i,
    output logic [RADDR_W-1:0]  r1_addr_o,
    output logic [RADDR_W-1:0]  r2_addr_o,
    input  logic [XLEN-1:0]     r1_data_i,
    input  logic [XLEN-1:0]     r2_data_i,
    input  logic                ex_w_en_i,
    input  logic [RADDR_W-1:0]  ex_w_addr_i,
    input  logic [XLEN-1:0]     ex_w_data_i,
    input  logic                ex_is_load_i,
    input  logic                mem_w_en_i,
    input  logic [RADDR_W-1:0]  mem_w_addr_i,
    input  logic [XLEN-1:0]     mem_w_data_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     pc_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic [XLEN-1:0]     op1_o,
    output logic [XLEN-1:0]     op2_o,
    output logic [XLEN-1:0]     imm_o,
    output logic                w_en_o,
    output logic [RADDR_W-1:0]  w_addr_o,
    output logic                illegal_o
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [ALUOP_W-1:0] EX_NOP_OP   = ALUOP_W'(8'h00);
    localparam logic [ALUOP_W-1:0] EX_ADD_OP   = ALUOP_W'(8'h01);
    localparam logic [ALUOP_W-1:0] EX_SUB_OP   = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] EX_SLL_OP   = ALUOP_W'(8'h03);
    localparam logic [ALUOP_W-1:0] EX_SLT_OP   = ALUOP_W'(8'h04);
    localparam logic [ALUOP_W-1:0] EX_SLTU_OP  = ALUOP_W'(8'h05);
    localparam logic [ALUOP_W-1:0] EX_XOR_OP   = ALUOP_W'(8'h06);
    localparam logic [ALUOP_W-1:0] EX_SRL_OP   = ALUOP_W'(8'h07);
    localparam logic [ALUOP_W-1:0] EX_SRA_OP   = ALUOP_W'(8'h08);
    localparam logic [ALUOP_W-1:0] EX_OR_OP    = ALUOP_W'(8'h09);
    localparam logic [ALUOP_W-1:0] EX_AND_OP   = ALUOP_W'(8'h0a);
    localparam logic [ALUOP_W-1:0] EX_LUI_OP   = ALUOP_W'(8'h0b);
    localparam logic [ALUOP_W-1:0] EX_AUIPC_OP = ALUOP_W'(8'h0c);
    localparam logic [ALUOP_W-1:0] EX_JAL_OP   = ALUOP_W'(8'h0d);
    localparam logic [ALUOP_W-1:0] EX_JALR_OP  = ALUOP_W'(8'h0e);
    // Load/store/branch ops are base + funct3 so EX can recover width/condition.
    localparam logic [ALUOP_W-1:0] EX_LOAD_OP  = ALUOP_W'(8'h10);
    localparam logic [ALUOP_W-1:0] EX_STORE_OP = ALUOP_W'(8'h18);
    localparam logic [ALUOP_W-1:0] EX_BR_OP    = ALUOP_W'(8'h20);

    localparam logic [ALUSEL_W-1:0] EX_RES_NOP   = ALUSEL_W'(3'd0);
    localparam logic [ALUSEL_W-1:0] EX_RES_LOGIC = ALUSEL_W'(3'd1);
    localparam logic [ALUSEL_W-1:0] EX_RES_SHIFT = ALUSEL_W'(3'd2);
    localparam logic [ALUSEL_W-1:0] EX_RES_ARITH = ALUSEL_W'(3'd3);
    localparam logic [ALUSEL_W-1:0] EX_RES_CMP   = ALUSEL_W'(3'd4);
    localparam logic [ALUSEL_W-1:0] EX_RES_JUMP  = ALUSEL_W'(3'd5);
    localparam logic [ALUSEL_W-1:0] EX_RES_LS    = ALUSEL_W'(3'd6);
    localparam logic [ALUSEL_W-1:0] EX_RES_BR    = ALUSEL_W'(3'd7);

    typedef enum logic [1:0] {OP1_RS1, OP1_ZERO, OP1_PC} op1_sel_e;

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [XLEN-1:0]     imm;
        logic                w_en;
        logic                illegal;
        logic                use_rs1;
        logic                use_rs2;
        logic                op2_rs2;
        op1_sel_e            op1_sel;
    } dec_t;

    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [RADDR_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_j, imm_u, shamt;
    dec_t               dec;
    logic [XLEN-1:0]    rs1_val, rs2_val, op1_d, op2_d;
    logic               stall, capture;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign rd     = inst_i[11:7];

    assign r1_addr_o = rs1;
    assign r2_addr_o = rs2;

    assign imm_i = XLEN'($signed(inst_i[31:20]));
    assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign shamt = XLEN'(inst_i[24:20]);

    always_comb begin
        dec         = '0;
        dec.aluop   = EX_NOP_OP;
        dec.alusel  = EX_RES_NOP;
        dec.op1_sel = OP1_RS1;
        case (opcode)
            OPC_OPIMM: begin
                dec.use_rs1 = 1'b1;
                dec.w_en    = 1'b1;
                dec.imm     = imm_i;
                case (f3)
                    3'b000: begin dec.aluop = EX_ADD_OP;  dec.alusel = EX_RES_ARITH; end
                    3'b010: begin dec.aluop = EX_SLT_OP;  dec.alusel = EX_RES_CMP;   end
                    3'b011: begin dec.aluop = EX_SLTU_OP; dec.alusel = EX_RES_CMP;   end
                    3'b100: begin dec.aluop = EX_XOR_OP;  dec.alusel = EX_RES_LOGIC; end
                    3'b110: begin dec.aluop = EX_OR_OP;   dec.alusel = EX_RES_LOGIC; end
                    3'b111: begin dec.aluop = EX_AND_OP;  dec.alusel = EX_RES_LOGIC; end
                    3'b001: begin
                        dec.aluop   = EX_SLL_OP;
                        dec.alusel  = EX_RES_SHIFT;
                        dec.imm     = shamt;
                        dec.illegal = (f7 != 7'h00);
                    end
                    default: begin
                        dec.aluop   = f7[5] ? EX_SRA_OP : EX_SRL_OP;
                        dec.alusel  = EX_RES_SHIFT;
                        dec.imm     = shamt;
                        dec.illegal = (f7 != 7'h00) && (f7 != 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.op2_rs2 = 1'b1;
                dec.w_en    = 1'b1;
                // funct7=0x20 is only meaningful for SUB and SRA.
                dec.illegal = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
                case (f3)
                    3'b000: begin dec.aluop = f7[5] ? EX_SUB_OP : EX_ADD_OP; dec.alusel = EX_RES_ARITH; end
                    3'b001: begin dec.aluop = EX_SLL_OP;  dec.alusel = EX_RES_SHIFT; end
                    3'b010: begin dec.aluop = EX_SLT_OP;  dec.alusel = EX_RES_CMP;   end
                    3'b011: begin dec.aluop = EX_SLTU_OP; dec.alusel = EX_RES_CMP;   end
                    3'b100: begin dec.aluop = EX_XOR_OP;  dec.alusel = EX_RES_LOGIC; end
                    3'b101: begin dec.aluop = f7[5] ? EX_SRA_OP : EX_SRL_OP; dec.alusel = EX_RES_SHIFT; end
                    3'b110: begin dec.aluop = EX_OR_OP;   dec.alusel = EX_RES_LOGIC; end
                    default: begin dec.aluop = EX_AND_OP; dec.alusel = EX_RES_LOGIC; end
                endcase
            end
            OPC_LUI: begin
                dec.w_en    = 1'b1;
                dec.imm     = imm_u;
                dec.op1_sel = OP1_ZERO;
                dec.aluop   = EX_LUI_OP;
                dec.alusel  = EX_RES_ARITH;
            end
            OPC_AUIPC: begin
                dec.w_en    = 1'b1;
                dec.imm     = imm_u;
                dec.op1_sel = OP1_PC;
                dec.aluop   = EX_AUIPC_OP;
                dec.alusel  = EX_RES_ARITH;
            end
            OPC_LOAD: begin
                dec.use_rs1 = 1'b1;
                dec.w_en    = 1'b1;
                dec.imm     = imm_i;
                dec.aluop   = EX_LOAD_OP + ALUOP_W'(f3);
                dec.alusel  = EX_RES_LS;
                dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.imm     = imm_s;
                dec.aluop   = EX_STORE_OP + ALUOP_W'(f3);
                dec.alusel  = EX_RES_LS;
                dec.illegal = (f3 > 3'b010);
            end
            OPC_BRANCH: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.op2_rs2 = 1'b1;
                dec.imm     = imm_b;
                dec.aluop   = EX_BR_OP + ALUOP_W'(f3);
                dec.alusel  = EX_RES_BR;
                dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                dec.w_en    = 1'b1;
                dec.imm     = imm_j;
                dec.op1_sel = OP1_PC;
                dec.aluop   = EX_JAL_OP;
                dec.alusel  = EX_RES_JUMP;
            end
            OPC_JALR: begin
                dec.use_rs1 = 1'b1;
                dec.w_en    = 1'b1;
                dec.imm     = imm_i;
                dec.aluop   = EX_JALR_OP;
                dec.alusel  = EX_RES_JUMP;
                dec.illegal = (f3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec.aluop   = EX_NOP_OP;
            dec.alusel  = EX_RES_NOP;
            dec.op1_sel = OP1_ZERO;
        end
        if (rd == '0)
            dec.w_en = 1'b0;
    end

    // x0 is never forwarded; EX result beats MEM result beats regfile.
    always_comb begin
        rs1_val = r1_data_i;
        if (rs1 == '0)                               rs1_val = '0;
        else if (ex_w_en_i && ex_w_addr_i == rs1)    rs1_val = ex_w_data_i;
        else if (mem_w_en_i && mem_w_addr_i == rs1)  rs1_val = mem_w_data_i;
    end

    always_comb begin
        rs2_val = r2_data_i;
        if (rs2 == '0)                               rs2_val = '0;
        else if (ex_w_en_i && ex_w_addr_i == rs2)    rs2_val = ex_w_data_i;
        else if (mem_w_en_i && mem_w_addr_i == rs2)  rs2_val = mem_w_data_i;
    end

    always_comb begin
        case (dec.op1_sel)
            OP1_PC:   op1_d = pc_i;
            OP1_ZERO: op1_d = '0;
            default:  op1_d = rs1_val;
        endcase
        op2_d = dec.op2_rs2 ? rs2_val : dec.imm;
    end

    assign stall = in_valid && ex_w_en_i && ex_is_load_i && (ex_w_addr_i != '0) &&
                   ((dec.use_rs1 && ex_w_addr_i == rs1) || (dec.use_rs2 && ex_w_addr_i == rs2));

    // Flush overrides stall/backpressure so the redirected fetch never blocks.
    assign in_ready = !rst && ((!stall && (!out_valid || out_ready)) || flush_i);
    assign capture  = in_ready && in_valid && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pc_o      <= '0;
            aluop_o   <= EX_NOP_OP;
            alusel_o  <= EX_RES_NOP;
            op1_o     <= '0;
            op2_o     <= '0;
            imm_o     <= '0;
            w_en_o    <= 1'b0;
            w_addr_o  <= '0;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            w_en_o    <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            pc_o      <= pc_i;
            aluop_o   <= dec.aluop;
            alusel_o  <= dec.alusel;
            op1_o     <= op1_d;
            op2_o     <= op2_d;
            imm_o     <= dec.imm;
            w_en_o    <= dec.w_en;
            w_addr_o  <= rd;
            illegal_o <= dec.illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed bench for id_stage_reg: decode, forwarding, load-use stall,
// backpressure hold, flush, illegal decode and reset.
module tb_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush_i, in_valid, in_ready;
    logic [31:0] pc_i, inst_i;
    logic [4:0]  r1_addr_o, r2_addr_o;
    logic [31:0] r1_data_i, r2_data_i;
    logic        ex_w_en_i, ex_is_load_i, mem_w_en_i;
    logic [4:0]  ex_w_addr_i, mem_w_addr_i;
    logic [31:0] ex_w_data_i, mem_w_data_i;
    logic        out_valid, out_ready;
    logic [31:0] pc_o, op1_o, op2_o, imm_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic        w_en_o, illegal_o;
    logic [4:0]  w_addr_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_stage_reg dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .r1_addr_o(r1_addr_o), .r2_addr_o(r2_addr_o),
        .r1_data_i(r1_data_i), .r2_data_i(r2_data_i),
        .ex_w_en_i(ex_w_en_i), .ex_w_addr_i(ex_w_addr_i),
        .ex_w_data_i(ex_w_data_i), .ex_is_load_i(ex_is_load_i),
        .mem_w_en_i(mem_w_en_i), .mem_w_addr_i(mem_w_addr_i), .mem_w_data_i(mem_w_data_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o),
        .w_en_o(w_en_o), .w_addr_o(w_addr_o), .illegal_o(illegal_o)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; in_valid = 0; pc_i = 0; inst_i = 32'h0000_0013;
        r1_data_i = 0; r2_data_i = 0;
        ex_w_en_i = 0; ex_w_addr_i = 0; ex_w_data_i = 0; ex_is_load_i = 0;
        mem_w_en_i = 0; mem_w_addr_i = 0; mem_w_data_i = 0;
        out_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++;
        if ({out_valid, w_en_o, illegal_o, pc_o, op1_o, op2_o, imm_o, w_addr_o, aluop_o, alusel_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b we=%0b il=%0b pc=%h op1=%h op2=%h imm=%h wa=%0d op=%h sel=%0d exp=all zero",
                     out_valid, w_en_o, illegal_o, pc_o, op1_o, op2_o, imm_o, w_addr_o, aluop_o, alusel_o);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_ori();
        in_valid = 1; pc_i = 32'h40; inst_i = 32'h0ff06093;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ori_in_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 0;
        checks++;
        if ({out_valid, op1_o, op2_o, imm_o, w_en_o, w_addr_o, aluop_o, alusel_o, pc_o} !==
            {1'b1, 32'h0, 32'hff, 32'hff, 1'b1, 5'd1, 8'h09, 3'd1, 32'h40}) begin
            failures++;
            $display("FAIL ori_decode got v=%0b op1=%h op2=%h imm=%h we=%0b wa=%0d op=%h sel=%0d pc=%h exp v=1 op1=0 op2=ff imm=ff we=1 wa=1 op=09 sel=1 pc=40",
                     out_valid, op1_o, op2_o, imm_o, w_en_o, w_addr_o, aluop_o, alusel_o, pc_o);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp_op1 [3];
        exp_op1[0] = 32'h10; exp_op1[1] = 32'h20; exp_op1[2] = 32'h7;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; inst_i = 32'h00508113; r1_data_i = 7;
            ex_w_en_i = (k == 0); ex_w_addr_i = 1; ex_w_data_i = 32'h10;
            mem_w_en_i = (k <= 1); mem_w_addr_i = 1; mem_w_data_i = 32'h20;
            #1;
            checks++; if (r1_addr_o !== 5'd1) begin failures++; $display("FAIL fwd_r1_addr got=%0d exp=1", r1_addr_o); end
            tick();
            checks++;
            if ({out_valid, op1_o, op2_o, w_addr_o, aluop_o} !== {1'b1, exp_op1[k], 32'h5, 5'd2, 8'h01}) begin
                failures++;
                $display("FAIL fwd_case%0d got v=%0b op1=%h op2=%h wa=%0d op=%h exp v=1 op1=%h op2=5 wa=2 op=01",
                         k, out_valid, op1_o, op2_o, w_addr_o, aluop_o, exp_op1[k]);
            end
        end
        // Writes to x0 must never be forwarded.
        inst_i = 32'h00500113; ex_w_en_i = 1; ex_w_addr_i = 0; ex_w_data_i = 32'h99;
        mem_w_en_i = 1; mem_w_addr_i = 0; mem_w_data_i = 32'h77; r1_data_i = 32'h55;
        tick();
        checks++; if (op1_o !== 32'h0) begin failures++; $display("FAIL fwd_x0 got op1=%h exp=0", op1_o); end
        idle();
    endtask

    task automatic test_load_use();
        // Load to a register the instruction does not read: no stall.
        in_valid = 1; inst_i = 32'h00508113; ex_w_en_i = 1; ex_is_load_i = 1; ex_w_addr_i = 5;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ldu_unrelated got in_ready=%0b exp=1", in_ready); end
        tick();
        inst_i = 32'h00118233; ex_w_addr_i = 3; ex_w_data_i = 32'hdead;
        r1_data_i = 5; r2_data_i = 32'h11;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ldu_stall got in_ready=%0b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ldu_bubble got out_valid=%0b exp=0", out_valid); end
        ex_w_en_i = 0; ex_is_load_i = 0; mem_w_en_i = 1; mem_w_addr_i = 3; mem_w_data_i = 32'h33;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ldu_release got in_ready=%0b exp=1", in_ready); end
        tick();
        checks++;
        if ({out_valid, op1_o, op2_o, w_addr_o, w_en_o, aluop_o, alusel_o} !==
            {1'b1, 32'h33, 32'h11, 5'd4, 1'b1, 8'h01, 3'd3}) begin
            failures++;
            $display("FAIL ldu_add got v=%0b op1=%h op2=%h wa=%0d we=%0b op=%h sel=%0d exp v=1 op1=33 op2=11 wa=4 we=1 op=01 sel=3",
                     out_valid, op1_o, op2_o, w_addr_o, w_en_o, aluop_o, alusel_o);
        end
        // Store reads rs2; a pending load to x2 must stall it.
        inst_i = 32'h0020a423; ex_w_en_i = 1; ex_is_load_i = 1; ex_w_addr_i = 2; mem_w_en_i = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ldu_store_rs2 got in_ready=%0b exp=0", in_ready); end
        idle();
        tick();
    endtask

    task automatic test_hold();
        in_valid = 1; pc_i = 32'h80; inst_i = 32'h0ff06093;
        tick();
        out_ready = 0; pc_i = 32'h84; inst_i = 32'h00508113; r1_data_i = 7;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, aluop_o, op2_o, pc_o, w_addr_o} !== {1'b0, 1'b1, 8'h09, 32'hff, 32'h80, 5'd1}) begin
                failures++;
                $display("FAIL hold_cycle%0d got rdy=%0b v=%0b op=%h op2=%h pc=%h wa=%0d exp rdy=0 v=1 op=09 op2=ff pc=80 wa=1",
                         c, in_ready, out_valid, aluop_o, op2_o, pc_o, w_addr_o);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got in_ready=%0b exp=1", in_ready); end
        tick();
        checks++;
        if ({out_valid, aluop_o, op1_o, pc_o, w_addr_o} !== {1'b1, 8'h01, 32'h7, 32'h84, 5'd2}) begin
            failures++;
            $display("FAIL hold_next got v=%0b op=%h op1=%h pc=%h wa=%0d exp v=1 op=01 op1=7 pc=84 wa=2",
                     out_valid, aluop_o, op1_o, pc_o, w_addr_o);
        end
    endtask

    task automatic test_flush();
        in_valid = 1; inst_i = 32'h0ff06093; flush_i = 1; out_ready = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        tick();
        checks++;
        if ({out_valid, w_en_o} !== 2'b00) begin
            failures++; $display("FAIL flush_kill got v=%0b we=%0b exp v=0 we=0", out_valid, w_en_o);
        end
        // Flush while a load-use stall is pending.
        flush_i = 0; out_ready = 1; inst_i = 32'h00118233; ex_w_en_i = 1; ex_is_load_i = 1; ex_w_addr_i = 3;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_stall got in_ready=%0b exp=0", in_ready); end
        flush_i = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_stall got in_ready=%0b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stall_out got v=%0b exp=0", out_valid); end
        idle();
    endtask

    task automatic test_classes();
        logic [31:0] insts [4];
        logic [31:0] e_op1 [4], e_op2 [4], e_imm [4];
        logic [7:0]  e_op  [4];
        logic [2:0]  e_sel [4];
        logic        e_we  [4];
        insts[0] = 32'h123450b7; e_op1[0] = 0;      e_op2[0] = 32'h12345000; e_imm[0] = 32'h12345000; e_op[0] = 8'h0b; e_sel[0] = 3; e_we[0] = 1;
        insts[1] = 32'hffdff0ef; e_op1[1] = 32'h100; e_op2[1] = 32'hfffffffc; e_imm[1] = 32'hfffffffc; e_op[1] = 8'h0d; e_sel[1] = 5; e_we[1] = 1;
        insts[2] = 32'h0020a423; e_op1[2] = 32'haa;  e_op2[2] = 32'h8;        e_imm[2] = 32'h8;        e_op[2] = 8'h1a; e_sel[2] = 6; e_we[2] = 0;
        insts[3] = 32'h4040d193; e_op1[3] = 32'haa;  e_op2[3] = 32'h4;        e_imm[3] = 32'h4;        e_op[3] = 8'h08; e_sel[3] = 2; e_we[3] = 1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; pc_i = 32'h100; inst_i = insts[k]; r1_data_i = 32'haa; r2_data_i = 32'hbb;
            tick();
            checks++;
            if ({out_valid, op1_o, op2_o, imm_o, aluop_o, alusel_o, w_en_o, illegal_o} !==
                {1'b1, e_op1[k], e_op2[k], e_imm[k], e_op[k], e_sel[k], e_we[k], 1'b0}) begin
                failures++;
                $display("FAIL class%0d got v=%0b op1=%h op2=%h imm=%h op=%h sel=%0d we=%0b il=%0b exp op1=%h op2=%h imm=%h op=%h sel=%0d we=%0b",
                         k, out_valid, op1_o, op2_o, imm_o, aluop_o, alusel_o, w_en_o, illegal_o,
                         e_op1[k], e_op2[k], e_imm[k], e_op[k], e_sel[k], e_we[k]);
            end
        end
        idle();
    endtask

    task automatic test_illegal_reset();
        in_valid = 1; pc_i = 32'h200; inst_i = 32'hffffffff;
        tick();
        checks++;
        if ({out_valid, illegal_o, w_en_o, aluop_o, alusel_o} !== {1'b1, 1'b1, 1'b0, 8'h00, 3'd0}) begin
            failures++;
            $display("FAIL illegal got v=%0b il=%0b we=%0b op=%h sel=%0d exp v=1 il=1 we=0 op=00 sel=0",
                     out_valid, illegal_o, w_en_o, aluop_o, alusel_o);
        end
        out_ready = 0; inst_i = 32'h0ff06093;
        tick();
        rst = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        tick();
        checks++;
        if ({out_valid, w_en_o, illegal_o, pc_o, op1_o, op2_o, imm_o, w_addr_o, aluop_o, alusel_o} !== '0) begin
            failures++;
            $display("FAIL rst_mid_hold got v=%0b we=%0b il=%0b pc=%h op1=%h op2=%h imm=%h wa=%0d op=%h sel=%0d exp=all zero",
                     out_valid, w_en_o, illegal_o, pc_o, op1_o, op2_o, imm_o, w_addr_o, aluop_o, alusel_o);
        end
        rst = 0; idle();
    endtask

    initial begin
        test_reset();
        test_ori();
        test_forwarding();
        test_load_use();
        test_hold();
        test_flush();
        test_classes();
        test_illegal_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
